tl45_wb_arbiter: RTL and testbench

- Two-master to one-slave Wishbone (pipelined, B4) arbiter that sits directly downstream of the instruction prefetch/cache stage's bus port.
- Master 0 is instruction fetch; master 1 is the data/memory stage. The single slave port drives the SDRAM/peripheral interconnect.
- Grant is held for a whole bus cycle, i.e. while the granted master holds CYC.
- A bus watchdog aborts a hung cycle with ERR so that fetch returns to IDLE instead of deadlocking.

---
 rtl/tl45_wb_pkg.sv | 21 ++
 rtl/tl45_wb_watchdog.sv | 47 ++++
 rtl/tl45_wb_arbiter.sv | 170 +++++++++++++++++
 tb/tb_tl45_wb_arbiter.sv | 331 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tl45_wb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : tl45_wb_pkg
// Description : Shared Wishbone widths and arbiter state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package tl45_wb_pkg;

  localparam int WB_AW = 30;
  localparam int WB_DW = 32;
  localparam int WB_SW = 4;

  typedef enum logic [1:0] {
    ARB_IDLE   = 2'd0,
    ARB_GRANT0 = 2'd1,
    ARB_GRANT1 = 2'd2,
    ARB_ABORT  = 2'd3
  } arb_state_t;

endpackage
`default_nettype wire

// File: rtl/tl45_wb_watchdog.sv
`default_nettype none
// ============================================================================
// Module      : tl45_wb_watchdog
// Description : Saturating wait-cycle counter; flags the cycle in which a
//               counted wait would reach TIMEOUT_CYCLES. 0 disables it.
// Revision    : 1.0 - initial release
// ============================================================================
module tl45_wb_watchdog #(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int TW             = 8
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_clear,
  input  logic i_count,
  output logic o_expired
);

  generate
    if (TIMEOUT_CYCLES == 0) begin : g_disabled
      logic w_unused;
      assign w_unused  = &{1'b0, i_clk, i_reset, i_clear, i_count};
      assign o_expired = 1'b0;
    end else begin : g_enabled
      localparam logic [TW-1:0] C_LIMIT = TW'(TIMEOUT_CYCLES);
      localparam logic [TW-1:0] C_MAX   = {TW{1'b1}};

      logic [TW-1:0] r_count;
      logic [TW:0]   w_count_next;

      // Count wait cycles; clear on any response or when the bus is released
      always_ff @(posedge i_clk) begin
        if (i_reset || i_clear) begin
          r_count <= '0;
        end else if (i_count && (r_count != C_MAX)) begin
          r_count <= r_count + 1'b1;
        end
      end

      // Expire in the cycle whose counted wait brings the total to the limit
      assign w_count_next = {1'b0, r_count} + {{TW{1'b0}}, 1'b1};
      assign o_expired    = i_count && (w_count_next >= {1'b0, C_LIMIT});
    end
  endgenerate

endmodule
`default_nettype wire

// File: rtl/tl45_wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tl45_wb_arbiter
// Description : Two-master to one-slave pipelined Wishbone arbiter. Master 0
//               is instruction fetch, master 1 is the data stage. Grant is
//               held for a whole bus cycle; a watchdog aborts hung cycles.
// Revision    : 1.0 - initial release
// ============================================================================
module tl45_wb_arbiter
  import tl45_wb_pkg::*;
#(
  parameter int OPT_ROUND_ROBIN = 0,
  parameter int TIMEOUT_CYCLES  = 255,
  parameter int TW              = 8
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_m0_cyc,
  input  logic             i_m0_stb,
  input  logic             i_m0_we,
  input  logic [WB_AW-1:0] i_m0_addr,
  input  logic [WB_DW-1:0] i_m0_data,
  input  logic [WB_SW-1:0] i_m0_sel,
  output logic             o_m0_ack,
  output logic             o_m0_stall,
  output logic             o_m0_err,
  output logic [WB_DW-1:0] o_m0_data,
  input  logic             i_m1_cyc,
  input  logic             i_m1_stb,
  input  logic             i_m1_we,
  input  logic [WB_AW-1:0] i_m1_addr,
  input  logic [WB_DW-1:0] i_m1_data,
  input  logic [WB_SW-1:0] i_m1_sel,
  output logic             o_m1_ack,
  output logic             o_m1_stall,
  output logic             o_m1_err,
  output logic [WB_DW-1:0] o_m1_data,
  output logic             o_wb_cyc,
  output logic             o_wb_stb,
  output logic             o_wb_we,
  output logic [WB_AW-1:0] o_wb_addr,
  output logic [WB_DW-1:0] o_wb_data,
  output logic [WB_SW-1:0] o_wb_sel,
  input  logic             i_wb_ack,
  input  logic             i_wb_stall,
  input  logic             i_wb_err,
  input  logic [WB_DW-1:0] i_wb_data,
  output logic [1:0]       o_grant
);

  arb_state_t r_state;
  arb_state_t w_next_state;
  // Master that holds the bus (or held it last, while idle); 1 after reset
  logic       r_owner;
  logic       r_abort_first;
  logic       w_owner_cyc;
  logic       w_in_grant;
  logic       w_tie_m0;
  logic       w_expired;
  logic       w_wd_count;
  logic       w_wd_clear;

  assign w_owner_cyc = r_owner ? i_m1_cyc : i_m0_cyc;
  assign w_in_grant  = (r_state == ARB_GRANT0) || (r_state == ARB_GRANT1);
  assign w_tie_m0    = (OPT_ROUND_ROBIN != 0) && r_owner;

  // Write-side paths follow the owner; cyc/stb gating makes them meaningful
  assign o_wb_addr = r_owner ? i_m1_addr : i_m0_addr;
  assign o_wb_data = r_owner ? i_m1_data : i_m0_data;
  assign o_wb_sel  = r_owner ? i_m1_sel  : i_m0_sel;
  assign o_wb_we   = w_in_grant && (r_owner ? i_m1_we : i_m0_we);
  assign o_m0_data = i_wb_data;
  assign o_m1_data = i_wb_data;

  assign w_wd_count = o_wb_cyc && !i_wb_ack && !i_wb_err;
  assign w_wd_clear = !w_in_grant || i_wb_ack || i_wb_err;

  tl45_wb_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
    .TW            (TW)
  ) u_watchdog (
    .i_clk    (i_clk),
    .i_reset  (i_reset),
    .i_clear  (w_wd_clear),
    .i_count  (w_wd_count),
    .o_expired(w_expired)
  );

  // State register, owner tracking and one-shot abort error flag
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state       <= ARB_IDLE;
      r_owner       <= 1'b1;
      r_abort_first <= 1'b0;
    end else begin
      r_state       <= w_next_state;
      if ((r_state == ARB_IDLE) && (w_next_state != ARB_IDLE)) begin
        r_owner <= (w_next_state == ARB_GRANT1);
      end
      r_abort_first <= (w_next_state == ARB_ABORT) && (r_state != ARB_ABORT);
    end
  end

  // Next-state: arbitrate from idle, hold while CYC, abort on watchdog expiry
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ARB_IDLE: begin
        if (i_m0_cyc && i_m1_cyc) begin
          w_next_state = w_tie_m0 ? ARB_GRANT0 : ARB_GRANT1;
        end else if (i_m1_cyc) begin
          w_next_state = ARB_GRANT1;
        end else if (i_m0_cyc) begin
          w_next_state = ARB_GRANT0;
        end
      end
      ARB_GRANT0: begin
        if (!i_m0_cyc)     w_next_state = ARB_IDLE;
        else if (w_expired) w_next_state = ARB_ABORT;
      end
      ARB_GRANT1: begin
        if (!i_m1_cyc)     w_next_state = ARB_IDLE;
        else if (w_expired) w_next_state = ARB_ABORT;
      end
      ARB_ABORT: begin
        if (!w_owner_cyc) w_next_state = ARB_IDLE;
      end
      default: w_next_state = ARB_IDLE;
    endcase
  end

  // Bus-side and master-side handshakes decoded from the current state
  always_comb begin
    o_wb_cyc   = 1'b0;
    o_wb_stb   = 1'b0;
    o_grant    = 2'b00;
    o_m0_ack   = 1'b0;
    o_m0_err   = 1'b0;
    o_m0_stall = 1'b1;
    o_m1_ack   = 1'b0;
    o_m1_err   = 1'b0;
    o_m1_stall = 1'b1;
    case (r_state)
      ARB_GRANT0: begin
        o_wb_cyc   = i_m0_cyc;
        o_wb_stb   = i_m0_cyc && i_m0_stb;
        o_grant    = 2'b01;
        o_m0_ack   = i_wb_ack;
        o_m0_err   = i_wb_err;
        o_m0_stall = i_wb_stall;
      end
      ARB_GRANT1: begin
        o_wb_cyc   = i_m1_cyc;
        o_wb_stb   = i_m1_cyc && i_m1_stb;
        o_grant    = 2'b10;
        o_m1_ack   = i_wb_ack;
        o_m1_err   = i_wb_err;
        o_m1_stall = i_wb_stall;
      end
      ARB_ABORT: begin
        o_grant = r_owner ? 2'b10 : 2'b01;
        if (r_owner) o_m1_err = r_abort_first;
        else         o_m0_err = r_abort_first;
      end
      default: ;
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_tl45_wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_tl45_wb_arbiter
// Description : Scoreboard bench for tl45_wb_arbiter. Two instances share the
//               stimulus: dut 0 fixed priority with a 4-cycle watchdog, dut 1
//               round-robin with the watchdog disabled.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_tl45_wb_arbiter;

  typedef struct packed {
    logic        cyc;
    logic        stb;
    logic        we;
    logic [29:0] addr;
    logic [31:0] data;
    logic [3:0]  sel;
    logic [1:0]  grant;
    logic [1:0]  ack;
    logic [1:0]  stall;
    logic [1:0]  err;
    logic [31:0] rd0;
    logic [31:0] rd1;
  } obs_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [1:0]  m_cyc, m_stb, m_we;
  logic [29:0] m_addr [2];
  logic [31:0] m_data [2];
  logic [3:0]  m_sel  [2];
  logic        s_ack, s_stall, s_err;
  logic [31:0] s_data;

  obs_t act [2];

  for (genvar g = 0; g < 2; g++) begin : g_dut
    logic        wb_cyc, wb_stb, wb_we;
    logic [29:0] wb_addr;
    logic [31:0] wb_dat, d0, d1;
    logic [3:0]  wb_sel;
    logic [1:0]  grant;
    logic        a0, a1, s0, s1, e0, e1;

    tl45_wb_arbiter #(
      .OPT_ROUND_ROBIN(g),
      .TIMEOUT_CYCLES ((g == 0) ? 4 : 0),
      .TW             (8)
    ) u_dut (
      .i_clk(clk), .i_reset(rst),
      .i_m0_cyc(m_cyc[0]), .i_m0_stb(m_stb[0]), .i_m0_we(m_we[0]),
      .i_m0_addr(m_addr[0]), .i_m0_data(m_data[0]), .i_m0_sel(m_sel[0]),
      .o_m0_ack(a0), .o_m0_stall(s0), .o_m0_err(e0), .o_m0_data(d0),
      .i_m1_cyc(m_cyc[1]), .i_m1_stb(m_stb[1]), .i_m1_we(m_we[1]),
      .i_m1_addr(m_addr[1]), .i_m1_data(m_data[1]), .i_m1_sel(m_sel[1]),
      .o_m1_ack(a1), .o_m1_stall(s1), .o_m1_err(e1), .o_m1_data(d1),
      .o_wb_cyc(wb_cyc), .o_wb_stb(wb_stb), .o_wb_we(wb_we),
      .o_wb_addr(wb_addr), .o_wb_data(wb_dat), .o_wb_sel(wb_sel),
      .i_wb_ack(s_ack), .i_wb_stall(s_stall), .i_wb_err(s_err),
      .i_wb_data(s_data), .o_grant(grant)
    );

    assign act[g] = {wb_cyc, wb_stb, wb_we, wb_addr, wb_dat, wb_sel, grant,
                     {a1, a0}, {s1, s0}, {e1, e0}, d0, d1};
  end

  // ---------------- reference model (transaction-level view) ----------------
  // own: -1 = nobody holds the bus, else the master index holding it
  int own [2];
  bit abrt [2];
  bit first [2];
  int waits [2];
  int last [2];

  function automatic int timeout_of(int d);
    return (d == 0) ? 4 : 0;
  endfunction

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      own[d] = -1; abrt[d] = 0; first[d] = 0; waits[d] = 0; last[d] = 1;
    end
  endtask

  function automatic obs_t model_out(int d);
    obs_t e;
    int   o;
    e = '0;
    e.rd0 = s_data;
    e.rd1 = s_data;
    e.stall = 2'b11;
    o = own[d];
    if (o >= 0) begin
      e.grant = (o == 0) ? 2'b01 : 2'b10;
      if (!abrt[d]) begin
        e.cyc  = m_cyc[o];
        e.stb  = m_cyc[o] & m_stb[o];
        e.we   = m_we[o];
        e.addr = m_addr[o];
        e.data = m_data[o];
        e.sel  = m_sel[o];
        e.stall[o] = s_stall;
        e.ack[o]   = s_ack;
        e.err[o]   = s_err;
      end else begin
        e.err[o] = first[d];
      end
    end
    return e;
  endfunction

  task automatic model_step(input int d);
    int o;
    o = own[d];
    if (rst) begin
      own[d] = -1; abrt[d] = 0; first[d] = 0; waits[d] = 0; last[d] = 1;
    end else if (o < 0) begin
      if (m_cyc == 2'b11) own[d] = (d == 1) ? (1 - last[d]) : 1;
      else if (m_cyc[0])  own[d] = 0;
      else if (m_cyc[1])  own[d] = 1;
      waits[d] = 0;
    end else if (abrt[d]) begin
      first[d] = 0;
      if (!m_cyc[o]) begin last[d] = o; own[d] = -1; abrt[d] = 0; end
    end else if (!m_cyc[o]) begin
      last[d] = o; own[d] = -1; waits[d] = 0;
    end else if (s_ack || s_err) begin
      waits[d] = 0;
    end else begin
      waits[d]++;
      if (timeout_of(d) > 0 && waits[d] >= timeout_of(d)) begin
        abrt[d] = 1; first[d] = 1; waits[d] = 0;
      end
    end
  endtask

  // ---------------- scoreboard ----------------
  obs_t q0 [$];
  obs_t q1 [$];
  int   checks = 0;
  int   failures = 0;
  int   ack0_cnt = 0, err0_cnt = 0, ack1_cnt = 0;
  logic [1:0] gseq [$];
  logic [1:0] prev_g1 = 2'b00;

  function automatic obs_t mask(obs_t o);
    if (!o.cyc) begin
      o.we = 1'b0; o.addr = '0; o.data = '0; o.sel = '0;
    end
    return o;
  endfunction

  function automatic void compare(int d, obs_t e);
    obs_t a, x;
    a = mask(act[d]);
    x = mask(e);
    checks++;
    if (a !== x) begin
      failures++;
      $display("FAIL cycle_dut%0d t=%0t actual=%h expected=%h", d, $time, a, x);
    end
  endfunction

  function automatic void check_eq(string name, int a, int x);
    checks++;
    if (a != x) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, a, x);
    end
  endfunction

  // Monitor: pop one expected record per cycle and compare against each DUT
  always @(negedge clk) begin
    if (q0.size() > 0) compare(0, q0.pop_front());
    if (q1.size() > 0) compare(1, q1.pop_front());
    if (act[0].ack[0]) ack0_cnt++;
    if (act[0].err[0]) err0_cnt++;
    if (act[0].ack[1]) ack1_cnt++;
    if (act[1].grant != prev_g1 && act[1].grant != 2'b00) gseq.push_back(act[1].grant);
    prev_g1 = act[1].grant;
  end

  // ---------------- stimulus ----------------
  bit   chk_en;
  bit   auto_ack;
  bit   acc;
  int   acc_owner;
  obs_t last_e0;

  task automatic tick();
    obs_t e0, e1;
    e0 = model_out(0);
    e1 = model_out(1);
    if (chk_en) begin q0.push_back(e0); q1.push_back(e1); end
    last_e0   = e0;
    acc       = e0.stb && !s_stall;
    acc_owner = e0.grant[1] ? 1 : 0;
    @(posedge clk);
    model_step(0);
    model_step(1);
    #1;
    if (auto_ack) s_ack = acc;
    s_data = $urandom;
  endtask

  task automatic run_masters(input int b0, input int b1);
    int left [2];
    int pend [2];
    left[0] = b0; left[1] = b1; pend[0] = b0; pend[1] = b1;
    m_cyc = {b1 > 0, b0 > 0};
    m_stb = m_cyc;
    for (int k = 0; k < 200 && m_cyc != 2'b00; k++) begin
      for (int m = 0; m < 2; m++) begin
        m_addr[m] = 30'($urandom); m_data[m] = $urandom;
        m_sel[m] = 4'($urandom); m_we[m] = 1'($urandom);
      end
      tick();
      if (acc) begin
        left[acc_owner]--;
        if (left[acc_owner] <= 0) m_stb[acc_owner] = 1'b0;
      end
      for (int m = 0; m < 2; m++) begin
        if (last_e0.ack[m]) pend[m]--;
        if (m_cyc[m] && left[m] <= 0 && pend[m] <= 0) begin
          m_cyc[m] = 1'b0; m_stb[m] = 1'b0;
        end
      end
    end
  endtask

  initial begin
    int nacc, base_a, base_e, base_gs;
    bit p0 [9];
    bit p1 [9];
    logic [1:0] gexp [3];

    rst = 1'b1; m_cyc = '0; m_stb = '0; m_we = '0;
    for (int i = 0; i < 2; i++) begin m_addr[i] = '0; m_data[i] = '0; m_sel[i] = '0; end
    s_ack = 0; s_stall = 0; s_err = 0; s_data = '0;
    auto_ack = 0; chk_en = 0;
    model_reset();
    @(posedge clk); #1;
    tick();
    chk_en = 1;
    tick(); tick();
    rst = 1'b0;

    // 16-beat fetch burst, slave acks with one-cycle latency
    auto_ack = 1; base_a = ack0_cnt; nacc = 0;
    m_cyc[0] = 1; m_stb[0] = 1; m_sel[0] = 4'hf; m_addr[0] = 30'h100;
    for (int k = 0; k < 100 && nacc < 16; k++) begin
      tick();
      if (acc) begin nacc++; m_addr[0] = m_addr[0] + 30'd1; end
    end
    m_stb[0] = 0; tick();
    m_cyc[0] = 0; tick(); tick();
    check_eq("m0_burst_acks", ack0_cnt - base_a, 16);

    // Simultaneous requests: master 1 first in both priority modes here
    run_masters(3, 3);
    tick(); tick();

    // Round-robin sequence from reset with both masters requesting
    rst = 1; tick(); rst = 0; auto_ack = 0; s_ack = 0;
    base_gs = gseq.size();
    p0 = '{1, 1, 0, 1, 1, 1, 1, 1, 0};
    p1 = '{1, 1, 1, 1, 1, 0, 1, 1, 1};
    for (int k = 0; k < 9; k++) begin
      m_cyc[0] = p0[k]; m_cyc[1] = p1[k]; m_stb = '0;
      tick();
    end
    m_cyc = '0; tick(); tick();
    gexp = '{2'b01, 2'b10, 2'b01};
    for (int k = 0; k < 3; k++)
      check_eq("rr_grant_seq", (base_gs + k < gseq.size()) ? int'(gseq[base_gs + k]) : 0,
               int'(gexp[k]));

    // Slave never answers: watchdog must abort with a single err pulse
    base_e = err0_cnt;
    m_cyc[0] = 1; m_stb[0] = 1;
    for (int k = 0; k < 9; k++) tick();
    m_cyc[0] = 0; m_stb[0] = 0; tick(); tick();
    check_eq("m0_timeout_err", err0_cnt - base_e, 1);

    // Ack on the 4th wait cycle wins over the watchdog
    base_e = err0_cnt; base_a = ack0_cnt;
    m_cyc[0] = 1; m_stb[0] = 1;
    tick(); tick();
    m_stb[0] = 0; tick(); tick();
    s_ack = 1; tick(); s_ack = 0;
    tick(); tick(); tick();
    m_cyc[0] = 0; tick(); tick();
    check_eq("m0_ack_at_limit_err", err0_cnt - base_e, 0);
    check_eq("m0_ack_at_limit_ack", ack0_cnt - base_a, 1);

    // Reset in the middle of a master-1 burst; late acks must be dropped
    auto_ack = 1; m_cyc[1] = 1; m_stb[1] = 1;
    for (int k = 0; k < 5; k++) tick();
    rst = 1; m_cyc[1] = 0; m_stb[1] = 0; tick();
    rst = 0; auto_ack = 0; base_a = ack1_cnt;
    s_ack = 1; tick(); tick(); s_ack = 0; tick();
    check_eq("m1_ack_after_reset", ack1_cnt - base_a, 0);

    // Randomized traffic
    for (int k = 0; k < 3000; k++) begin
      rst = ($urandom_range(199) == 0);
      for (int m = 0; m < 2; m++) begin
        if (!m_cyc[m]) m_cyc[m] = ($urandom_range(3) == 0);
        else if ($urandom_range(7) == 0) m_cyc[m] = 1'b0;
        m_stb[m] = m_cyc[m] & 1'($urandom);
        m_we[m] = 1'($urandom); m_addr[m] = 30'($urandom);
        m_data[m] = $urandom; m_sel[m] = 4'($urandom);
      end
      s_ack = ($urandom_range(9) < 4);
      s_stall = ($urandom_range(9) < 3);
      s_err = ($urandom_range(19) == 0);
      tick();
    end
    rst = 0; m_cyc = '0; m_stb = '0; s_ack = 0; s_err = 0; s_stall = 0;
    tick();
    @(negedge clk); @(negedge clk);
    check_eq("scoreboard_drain", q0.size() + q1.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
